masked_sbox_layer: RTL and testbench

MASKED_SBOX_LAYER -- requirements
Module: masked_sbox_layer

---
 rtl/masked_sbox_layer.sv | 227 ++++++++++++++++++++++
 tb/tb_masked_sbox_layer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_layer.sv
// masked_sbox_layer: first-order masked PRINCE forward S-box layer, 4 lanes x 4 groups. Optional MASK_REFRESH_EN adds port rr.
// Latency: out_valid rises on the 5th rising edge after the acceptance edge (6 cycles after acceptance). Throughput: one state per 7 cycles.
// Backpressure: in_ready only in IDLE; the result holds stable in HOLD until out_valid & out_ready.

// One masked S-box lane: 16 share-domain terms, refreshed and registered, then compressed to two shares.
module masked_sbox_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [3:0]  a_x_i,
  input  logic [3:0]  a_y_i,
  input  logic [35:0] r_i,
  output logic [3:0]  b_x_o,
  output logic [3:0]  b_y_o
);

  logic [3:0] dom_d [16];
  logic [3:0] dom_q [16];

  function automatic logic [3:0] sbox_f(input logic [3:0] v);
    logic [3:0] s;
    case (v)
      4'h0: s = 4'hB;
      4'h1: s = 4'hF;
      4'h2: s = 4'h3;
      4'h3: s = 4'h2;
      4'h4: s = 4'hA;
      4'h5: s = 4'hC;
      4'h6: s = 4'h9;
      4'h7: s = 4'h1;
      4'h8: s = 4'h6;
      4'h9: s = 4'h7;
      4'hA: s = 4'h8;
      4'hB: s = 4'h0;
      4'hC: s = 4'hE;
      4'hD: s = 4'h5;
      4'hE: s = 4'hD;
      default: s = 4'h4;
    endcase
    return s;
  endfunction

  // Domain s takes y bits where s is 1 and x bits where s is 0, so no term ever sees both
  // shares of one input bit. Its value is prod(y_i, i in s) times the XOR of S over all
  // assignments of the s-bits (the ANF coefficient sum of monomials covering s), evaluated
  // at the x bits outside s. The XOR of all 16 domains equals S(x ^ y).
  function automatic logic [3:0] domain_f(input logic [3:0] s, input logic [3:0] xs,
                                          input logic [3:0] ys);
    logic [3:0] acc;
    acc = 4'h0;
    for (int a = 0; a < 16; a++) begin
      if ((4'(a) & ~s) == 4'h0) acc = acc ^ sbox_f((xs & ~s) | 4'(a));
    end
    if ((ys & s) != s) acc = 4'h0;
    return acc;
  endfunction

  // Domain terms plus masks; r nibble k covers domains k and k+8, r nibble 8 covers domains 1 and 2,
  // so every mask cancels in the final sum.
  always_comb begin
    logic [3:0] m;
    m = 4'h0;
    for (int k = 0; k < 16; k++) begin
      m = r_i[4*(k%8) +: 4];
      if (k == 1 || k == 2) m = m ^ r_i[35:32];
      dom_d[k] = domain_f(4'(k), a_x_i, a_y_i) ^ m;
    end
  end

  // The single lane register stage; holds its value while the lane is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) dom_q[k] <= 4'h0;
    end else if (en_i) begin
      for (int k = 0; k < 16; k++) dom_q[k] <= dom_d[k];
    end
  end

  // Compression after the register: domains 0..7 form share 0, domains 8..15 form share 1.
  always_comb begin
    b_x_o = 4'h0;
    b_y_o = 4'h0;
    for (int k = 0; k < 8; k++) begin
      b_x_o = b_x_o ^ dom_q[k];
      b_y_o = b_y_o ^ dom_q[k+8];
    end
  end

endmodule

module masked_sbox_layer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  x,
  input  logic [63:0]  y,
  input  logic [143:0] r,
`ifdef MASK_REFRESH_EN
  input  logic [63:0]  rr,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  z_x,
  output logic [63:0]  z_y
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic        wr_vld_q;
  logic [1:0]  wr_grp_q;
  logic [63:0] sx_q, sy_q;
  logic [63:0] zx_q, zx_d, zy_q, zy_d;
  logic        issue, accept;

  logic [3:0] lane_ax [4];
  logic [3:0] lane_ay [4];
  logic [3:0] lane_bx [4];
  logic [3:0] lane_by [4];

  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign lane_ax[j] = sx_q[{cnt_q, 2'(j), 2'b00} +: 4];
    assign lane_ay[j] = sy_q[{cnt_q, 2'(j), 2'b00} +: 4];

    masked_sbox_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (issue),
      .a_x_i (lane_ax[j]),
      .a_y_i (lane_ay[j]),
      .r_i   (r[36*j +: 36]),
      .b_x_o (lane_bx[j]),
      .b_y_o (lane_by[j])
    );
  end

  // Control: IDLE accepts, RUN issues groups 0..3 then spends one drain cycle, HOLD waits for the consumer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
          cnt_d   = 2'd0;
          drain_d = 1'b0;
        end
      end
      RUN: begin
        if (drain_q) begin
          state_d = HOLD;
          drain_d = 1'b0;
        end else begin
          issue = 1'b1;
          if (cnt_q == 2'd3) drain_d = 1'b1;
          else               cnt_d   = cnt_q + 2'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Group write-back one cycle after issue, optionally re-masked with the same rr nibble on both shares.
  always_comb begin
    logic [3:0] rr_nib;
    zx_d   = zx_q;
    zy_d   = zy_q;
    rr_nib = 4'h0;
    if (wr_vld_q) begin
      for (int j = 0; j < 4; j++) begin
`ifdef MASK_REFRESH_EN
        rr_nib = rr[{wr_grp_q, 2'(j), 2'b00} +: 4];
`else
        rr_nib = 4'h0;
`endif
        zx_d[{wr_grp_q, 2'(j), 2'b00} +: 4] = lane_bx[j] ^ rr_nib;
        zy_d[{wr_grp_q, 2'(j), 2'b00} +: 4] = lane_by[j] ^ rr_nib;
      end
    end
  end

  // State, counters, captured input shares and output shares.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      drain_q  <= 1'b0;
      wr_vld_q <= 1'b0;
      wr_grp_q <= 2'd0;
      sx_q     <= '0;
      sy_q     <= '0;
      zx_q     <= '0;
      zy_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      wr_vld_q <= issue;
      wr_grp_q <= cnt_q;
      zx_q     <= zx_d;
      zy_q     <= zy_d;
      if (accept) begin
        sx_q <= x;
        sy_q <= y;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign z_x       = zx_q;
  assign z_y       = zy_q;

endmodule

// File: tb/tb_masked_sbox_layer.sv
// tb_masked_sbox_layer: directed checks of the masked PRINCE S-box layer.
// Latency: drives one state at a time and waits (bounded) for the result.
// Backpressure: holds out_ready low in HOLD and checks stability.
module tb_masked_sbox_layer;

`ifdef MASK_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  localparam logic [63:0] V1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] S_V1 = 64'hBF32AC916780E5D4;
  localparam logic [63:0] V2X  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] S_V2 = 64'h4D5E087619CA23FB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  x = '0;
  logic [63:0]  y = '0;
  logic [143:0] r = '0;
  logic [63:0]  rr = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  z_x, z_y;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_r   = 1'b1;

  always #5 clk = ~clk;

  masked_sbox_layer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .r         (r),
`ifdef MASK_REFRESH_EN
    .rr        (rr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_x       (z_x),
    .z_y       (z_y)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and present fresh randomness.
  task automatic tick();
    logic [159:0] w;
    @(negedge clk);
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = rand_r ? w[143:0] : '0;
  endtask

  // One full transaction with out_ready high; returns the shares seen in HOLD.
  task automatic run_op(input string tag, input logic [63:0] vx, input logic [63:0] vy,
                        input logic [63:0] exp, output logic [63:0] gzx, output logic [63:0] gzy);
    int lat;
    tick();
    in_valid = 1'b1;
    x = vx;
    y = vy;
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd5);
    check({tag, " unmasked result"}, z_x ^ z_y, exp);
    gzx = z_x;
    gzy = z_y;
    tick();
    check({tag, " idle after handshake"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [63:0] gx, gy, hx, hy;
    int lat, seen;

    // Reset for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset z_x", z_x, 64'd0);
    check("reset z_y", z_y, 64'd0);
    rst = 1'b0;

    // Basic vector with y = 0 and zero randomness: shares are raw (or rr-refreshed)
    rand_r = 1'b0;
    rr = 64'hA5A5A5A5A5A5A5A5;
    run_op("basic", V1, 64'd0, S_V1, gx, gy);
    check("basic z_x", gx, S_V1 ^ (REFRESH ? rr : 64'd0));
    check("basic z_y", gy, REFRESH ? rr : 64'd0);
    rand_r = 1'b1;

    // Second vector with random masks, many randomness sequences
    for (int i = 0; i < 1000; i++) begin
      rr = {$urandom(), $urandom()};
      run_op("random r", V2X, V1, S_V2, gx, gy);
    end

    // Backpressure: out_ready low, in_valid held with a different pending state
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    x = V1;
    y = 64'd0;
    tick();
    x = V2X;
    y = V1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp latency", 64'(lat), 64'd5);
    check("bp result", z_x ^ z_y, S_V1);
    hx = z_x;
    hy = z_y;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp hold flags", 64'({in_ready, out_valid}), 64'b01);
      check("bp z_x stable", z_x, hx);
      check("bp z_y stable", z_y, hy);
    end
    out_ready = 1'b1;
    tick();
    check("bp released", 64'({in_ready, out_valid}), 64'b10);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp second latency", 64'(lat), 64'd5);
    check("bp second result", z_x ^ z_y, S_V2);
    tick();

    // Reset pulsed while cnt = 2
    tick();
    in_valid = 1'b1;
    x = V1;
    y = 64'd0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort flags", 64'({in_ready, out_valid}), 64'b10);
    check("abort z_x", z_x, 64'd0);
    check("abort z_y", z_y, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort no out_valid", 64'(seen), 64'd0);
    run_op("after abort", V2X, V1, S_V2, gx, gy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
